data_generator_mc: RTL

DATA_GENERATOR_MC -- requirements
Module: data_generator_mc

---
 rtl/data_generator_mc.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/data_generator_mc.sv
`default_nettype none
// ============================================================================
//  Module   : data_generator_mc
//  Brief    : Button-driven multi-channel signed counter with debounced,
//             auto-repeating Up/Down and one-shot Clear/Sign/Select.
//  Revision : 1.0 - initial release
// ============================================================================
module data_generator_mc #(
    parameter int    Size               = 5,
    parameter int    Channels           = 4,
    parameter string Mode               = "Wrap",
    parameter int    ClockPeriod_ns     = 20,
    parameter int    FilterPeriod_ns    = 1_000_000,
    parameter int    PauseInterval_ns   = 450_000_000,
    parameter int    RepeatsInterval_ns = 150_000_000
) (
    input  logic                                            Clock,
    input  logic                                            Reset,
    input  logic                                            Button_Up,
    input  logic                                            Button_Down,
    input  logic                                            Button_Clear,
    input  logic                                            Button_Sign,
    input  logic                                            Button_Select,
    output logic [Size-1:0]                                 Data,
    output logic                                            SigneBit,
    output logic [((Channels > 1) ? $clog2(Channels) : 1)-1:0] Channel,
    output logic [Channels*(Size+1)-1:0]                    AllData,
    output logic                                            Limit
);

    localparam int c_chan_w  = (Channels > 1) ? $clog2(Channels) : 1;
    localparam int c_nb      = 5;
    localparam int c_up      = 0;
    localparam int c_dn      = 1;
    localparam int c_clr     = 2;
    localparam int c_sgn     = 3;
    localparam int c_sel     = 4;

    localparam int c_fc_raw  = FilterPeriod_ns / ClockPeriod_ns;
    localparam int c_pc_raw  = PauseInterval_ns / ClockPeriod_ns;
    localparam int c_rc_raw  = RepeatsInterval_ns / ClockPeriod_ns;
    localparam int c_fc      = (c_fc_raw < 1) ? 1 : c_fc_raw;
    localparam int c_pc      = (c_pc_raw < 1) ? 1 : c_pc_raw;
    localparam int c_rc      = (c_rc_raw < 1) ? 1 : c_rc_raw;
    localparam int c_top_a   = (c_fc > c_pc) ? c_fc : c_pc;
    localparam int c_cnt_top = (c_top_a > c_rc) ? c_top_a : c_rc;
    localparam int c_cnt_w   = (c_cnt_top < 2) ? 1 : $clog2(c_cnt_top);

    localparam logic [c_cnt_w-1:0]  c_fc_m1     = c_cnt_w'(c_fc - 1);
    localparam logic [c_cnt_w-1:0]  c_pc_m1     = c_cnt_w'(c_pc - 1);
    localparam logic [c_cnt_w-1:0]  c_rc_m1     = c_cnt_w'(c_rc - 1);
    localparam logic [Size-1:0]     c_mag_max   = '1;
    localparam logic [c_chan_w-1:0] c_chan_last = c_chan_w'(Channels - 1);
    localparam bit                  c_saturate  = (Mode == "Saturate");

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PAUSE  = 2'd1,
        S_REPEAT = 2'd2
    } rep_state_t;

    logic [c_nb-1:0] w_raw;
    logic [c_nb-1:0] r_sync1;
    logic [c_nb-1:0] r_sync2;
    logic [c_nb-1:0] w_filt;
    logic [c_nb-1:0] w_step;
    logic [2:0]      r_press_d;

    assign w_raw = {Button_Select, Button_Sign, Button_Clear, Button_Down, Button_Up};

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Filtered level flips only after c_fc consecutive disagreeing samples.
    for (genvar b = 0; b < c_nb; b++) begin : g_btn
        logic [c_cnt_w-1:0] r_cnt;
        logic               r_level;

        always_ff @(posedge Clock) begin
            if (Reset) begin
                r_cnt   <= '0;
                r_level <= 1'b0;
            end else if (r_sync2[b] != r_level) begin
                if (r_cnt == c_fc_m1) begin
                    r_cnt   <= '0;
                    r_level <= r_sync2[b];
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end

        assign w_filt[b] = r_level;
    end

    for (genvar r = 0; r < 2; r++) begin : g_rep
        rep_state_t         r_state;
        rep_state_t         w_state_nxt;
        logic [c_cnt_w-1:0] r_cnt;
        logic [c_cnt_w-1:0] w_cnt_nxt;
        logic               w_pulse;

        always_ff @(posedge Clock) begin
            if (Reset) begin
                r_state <= S_IDLE;
                r_cnt   <= '0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
            end
        end

        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            w_pulse     = 1'b0;
            if (!w_filt[r]) begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        w_pulse     = 1'b1;
                        w_state_nxt = S_PAUSE;
                        w_cnt_nxt   = c_pc_m1;
                    end
                    S_PAUSE, S_REPEAT: begin
                        if (r_cnt == '0) begin
                            w_pulse     = 1'b1;
                            w_state_nxt = S_REPEAT;
                            w_cnt_nxt   = c_rc_m1;
                        end else begin
                            w_cnt_nxt = r_cnt - 1'b1;
                        end
                    end
                    default: begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = '0;
                    end
                endcase
            end
        end

        assign w_step[r] = w_pulse;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_press_d <= '0;
        end else begin
            r_press_d <= w_filt[c_sel:c_clr];
        end
    end

    assign w_step[c_sel:c_clr] = w_filt[c_sel:c_clr] & ~r_press_d;

    logic [Size-1:0]     r_mag [Channels];
    logic [Channels-1:0] r_sign;
    logic [c_chan_w-1:0] r_chan;
    logic                r_limit;

    logic                w_inc;
    logic                w_dec;
    logic [Size-1:0]     w_cur_mag;
    logic                w_cur_sign;
    logic [Size-1:0]     w_nxt_mag;
    logic                w_nxt_sign;
    logic                w_limit_nxt;
    logic [c_chan_w-1:0] w_chan_nxt;

    // Simultaneous Up and Down cancel each other out entirely.
    assign w_inc = w_step[c_up] & ~w_step[c_dn];
    assign w_dec = w_step[c_dn] & ~w_step[c_up];

    always_comb begin
        w_cur_mag   = r_mag[r_chan];
        w_cur_sign  = r_sign[r_chan];
        w_nxt_mag   = w_cur_mag;
        w_nxt_sign  = w_cur_sign;
        w_limit_nxt = 1'b0;
        w_chan_nxt  = r_chan;

        if (w_step[c_clr]) begin
            w_nxt_mag  = '0;
            w_nxt_sign = 1'b0;
        end else begin
            if (w_step[c_sgn]) begin
                w_nxt_sign = ~w_cur_sign;
            end
            if (w_inc) begin
                if (w_cur_mag == c_mag_max) begin
                    w_limit_nxt = 1'b1;
                    w_nxt_mag   = c_saturate ? c_mag_max : '0;
                end else begin
                    w_nxt_mag = w_cur_mag + 1'b1;
                end
            end else if (w_dec) begin
                if (w_cur_mag == '0) begin
                    w_limit_nxt = 1'b1;
                    w_nxt_mag   = c_saturate ? '0 : c_mag_max;
                end else begin
                    w_nxt_mag = w_cur_mag - 1'b1;
                end
            end
        end

        if (w_step[c_sel]) begin
            w_chan_nxt = (r_chan == c_chan_last) ? '0 : r_chan + 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int i = 0; i < Channels; i++) begin
                r_mag[i] <= '0;
            end
            r_sign  <= '0;
            r_chan  <= '0;
            r_limit <= 1'b0;
        end else begin
            for (int i = 0; i < Channels; i++) begin
                if (r_chan == c_chan_w'(i)) begin
                    r_mag[i]  <= w_nxt_mag;
                    r_sign[i] <= w_nxt_sign;
                end
            end
            r_chan  <= w_chan_nxt;
            r_limit <= w_limit_nxt;
        end
    end

    for (genvar i = 0; i < Channels; i++) begin : g_all
        assign AllData[i*(Size+1) +: Size+1] = {r_sign[i], r_mag[i]};
    end

    assign Data     = r_mag[r_chan];
    assign SigneBit = r_sign[r_chan];
    assign Channel  = r_chan;
    assign Limit    = r_limit;

endmodule
`default_nettype wire
